// File: rtl/rename_map_ckpt_pkg.sv
// rename_map_ckpt_pkg: shared sizes and types for the rename map and its checkpoint allocator
package rename_map_ckpt_pkg;
  localparam int ARCH_REGS = 32;
  localparam int ROB_SZ = 32;
  localparam int TAG_W = $clog2(ROB_SZ + 1);
  localparam int N_CKPT = 4;
  localparam int DP_W = 2;
  localparam int CDB_W = 1;
  localparam int REG_W = $clog2(ARCH_REGS);
  localparam int CKPT_W = $clog2(N_CKPT);
  localparam int CNT_W = $clog2(N_CKPT + 1);
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic t_plus;
  } MAP_ENTRY;
  typedef logic [CKPT_W-1:0] CKPT_ID;
endpackage

// File: rtl/rename_ckpt_alloc.sv
// rename_ckpt_alloc: checkpoint slot bitmap, lowest-free allocation and age ordering
module rename_ckpt_alloc
  import rename_map_ckpt_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DP_W-1:0]        i_req,
  input  logic                   i_drop,
  input  logic                   i_br_valid,
  input  logic                   i_br_mispredict,
  input  logic [N_CKPT-1:0]      i_match,
  output logic                   o_stall,
  output logic [DP_W-1:0]        o_gnt,
  output logic [DP_W*CKPT_W-1:0] o_slot,
  output logic [N_CKPT-1:0]      o_live,
  output logic [CNT_W-1:0]       o_free_cnt
);
  logic [N_CKPT-1:0] r_live, w_avail, w_free, w_alloc;
  // bit j of row i set: slot i is younger than slot j
  logic [N_CKPT-1:0] r_younger [N_CKPT];
  logic [N_CKPT-1:0] w_row [DP_W];
  logic [CNT_W-1:0] w_nreq;
  logic w_found;
  assign o_live = r_live;
  always_comb begin
    o_free_cnt = '0;
    w_nreq = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_CKPT; i++) o_free_cnt += CNT_W'(!r_live[i]);
    for (int k = 0; k < DP_W; k++) w_nreq += CNT_W'(i_req[k]);
    o_stall = w_nreq > o_free_cnt;
    o_gnt = i_req & {DP_W{!o_stall && !i_drop}};
    w_avail = ~r_live;
    w_alloc = '0;
    o_slot = '0;
    for (int k = 0; k < DP_W; k++) begin
      w_row[k] = ~w_avail;
      w_found = 1'b0;
      for (int i = 0; i < N_CKPT; i++)
        if (o_gnt[k] && !w_found && w_avail[i]) begin
          o_slot[k*CKPT_W +: CKPT_W] = CKPT_ID'(i);
          w_alloc[i] = 1'b1;
          w_avail[i] = 1'b0;
          w_found = 1'b1;
        end
    end
    for (int i = 0; i < N_CKPT; i++)
      w_free[i] = i_br_valid && (i_match[i] || (i_br_mispredict && |(i_match & r_younger[i])));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_live <= '0;
      for (int i = 0; i < N_CKPT; i++) r_younger[i] <= '0;
    end else begin
      r_live <= (r_live & ~w_free) | w_alloc;
      for (int k = 0; k < DP_W; k++)
        if (o_gnt[k]) begin
          for (int i = 0; i < N_CKPT; i++) r_younger[i][o_slot[k*CKPT_W +: CKPT_W]] <= 1'b0;
          r_younger[o_slot[k*CKPT_W +: CKPT_W]] <= w_row[k];
        end
    end
  end
endmodule

// File: rtl/rename_map_ckpt.sv
// rename_map_ckpt: rename map table with multi-way dispatch and age-ordered branch checkpoints
module rename_map_ckpt
  import rename_map_ckpt_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DP_W-1:0]        i_dp_valid,
  input  logic [DP_W-1:0]        i_dp_has_dest,
  input  logic [DP_W*REG_W-1:0]  i_dp_dest_idx,
  input  logic [DP_W*TAG_W-1:0]  i_dp_rob_tag,
  input  logic [DP_W-1:0]        i_dp_is_branch,
  input  logic [DP_W*REG_W-1:0]  i_dp_rs1_idx,
  input  logic [DP_W*REG_W-1:0]  i_dp_rs2_idx,
  output logic [DP_W*TAG_W-1:0]  o_src1_tag,
  output logic [DP_W*TAG_W-1:0]  o_src2_tag,
  output logic [DP_W-1:0]        o_src1_ready,
  output logic [DP_W-1:0]        o_src2_ready,
  output logic                   o_dp_stall,
  input  logic [CDB_W-1:0]       i_cdb_valid,
  input  logic [CDB_W*TAG_W-1:0] i_cdb_tag,
  input  logic                   i_retire_valid,
  input  logic [TAG_W-1:0]       i_retire_tag,
  input  logic                   i_br_valid,
  input  logic                   i_br_mispredict,
  input  logic [TAG_W-1:0]       i_br_tag,
  output logic [CNT_W-1:0]       o_ckpt_free_cnt
);
  MAP_ENTRY r_map [ARCH_REGS];
  MAP_ENTRY r_snap [N_CKPT][ARCH_REGS];
  logic [TAG_W-1:0] r_snap_tag [N_CKPT];
  MAP_ENTRY w_tbl [ARCH_REGS];
  MAP_ENTRY w_stage [DP_W][ARCH_REGS];
  MAP_ENTRY w_e1, w_e2;
  logic [N_CKPT-1:0] w_live, w_match;
  CKPT_ID w_sel;
  logic [DP_W-1:0] w_gnt, w_wr;
  logic [DP_W*CKPT_W-1:0] w_slot;
  logic w_stall, w_mp;
  function automatic logic cdb_hit(input logic [TAG_W-1:0] t);
    cdb_hit = 1'b0;
    for (int c = 0; c < CDB_W; c++)
      cdb_hit |= i_cdb_valid[c] && t != '0 && i_cdb_tag[c*TAG_W +: TAG_W] == t;
  endfunction
  function automatic MAP_ENTRY upd(input MAP_ENTRY e);
    upd = e;
    if (cdb_hit(e.tag)) upd.t_plus = 1'b1;
    if (i_retire_valid && e.tag == i_retire_tag) upd = '0;
  endfunction
  rename_ckpt_alloc u_alloc (
    .clock(clock), .reset(reset), .i_req(i_dp_valid & i_dp_is_branch), .i_drop(w_mp),
    .i_br_valid(i_br_valid), .i_br_mispredict(i_br_mispredict), .i_match(w_match),
    .o_stall(w_stall), .o_gnt(w_gnt), .o_slot(w_slot), .o_live(w_live), .o_free_cnt(o_ckpt_free_cnt)
  );
  assign o_dp_stall = w_stall && !reset;
  always_comb begin
    w_match = '0;
    w_sel = '0;
    for (int s = 0; s < N_CKPT; s++)
      if (w_live[s] && r_snap_tag[s] == i_br_tag) begin
        w_match[s] = 1'b1;
        w_sel = CKPT_ID'(s);
      end
    w_mp = i_br_valid && i_br_mispredict && |w_match;
  end
  // w_stage[k] is the table as seen right after way k, which is what its checkpoint stores
  always_comb begin
    for (int r = 0; r < ARCH_REGS; r++) w_tbl[r] = upd(w_mp ? r_snap[w_sel][r] : r_map[r]);
    for (int k = 0; k < DP_W; k++) begin
      if (w_wr[k] && !w_stall && !w_mp)
        w_tbl[i_dp_dest_idx[k*REG_W +: REG_W]] = {i_dp_rob_tag[k*TAG_W +: TAG_W], 1'b0};
      w_stage[k] = w_tbl;
    end
  end
  always_comb begin
    o_src1_tag = '0;
    o_src2_tag = '0;
    o_src1_ready = '0;
    o_src2_ready = '0;
    w_e1 = '0;
    w_e2 = '0;
    for (int k = 0; k < DP_W; k++) begin
      w_wr[k] = i_dp_valid[k] && i_dp_has_dest[k] && i_dp_dest_idx[k*REG_W +: REG_W] != '0;
      w_e1 = r_map[i_dp_rs1_idx[k*REG_W +: REG_W]];
      w_e2 = r_map[i_dp_rs2_idx[k*REG_W +: REG_W]];
      for (int j = 0; j < k; j++) begin
        if (w_wr[j] && i_dp_dest_idx[j*REG_W +: REG_W] == i_dp_rs1_idx[k*REG_W +: REG_W])
          w_e1 = {i_dp_rob_tag[j*TAG_W +: TAG_W], 1'b0};
        if (w_wr[j] && i_dp_dest_idx[j*REG_W +: REG_W] == i_dp_rs2_idx[k*REG_W +: REG_W])
          w_e2 = {i_dp_rob_tag[j*TAG_W +: TAG_W], 1'b0};
      end
      if (i_dp_valid[k] && !reset) begin
        o_src1_tag[k*TAG_W +: TAG_W] = w_e1.tag;
        o_src2_tag[k*TAG_W +: TAG_W] = w_e2.tag;
        o_src1_ready[k] = w_e1.tag == '0 || w_e1.t_plus || cdb_hit(w_e1.tag);
        o_src2_ready[k] = w_e2.tag == '0 || w_e2.t_plus || cdb_hit(w_e2.tag);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < ARCH_REGS; r++) r_map[r] <= '0;
      for (int s = 0; s < N_CKPT; s++) begin
        r_snap_tag[s] <= '0;
        for (int r = 0; r < ARCH_REGS; r++) r_snap[s][r] <= '0;
      end
    end else begin
      r_map <= w_tbl;
      for (int s = 0; s < N_CKPT; s++)
        for (int r = 0; r < ARCH_REGS; r++) r_snap[s][r] <= upd(r_snap[s][r]);
      for (int k = 0; k < DP_W; k++)
        if (w_gnt[k]) begin
          r_snap[w_slot[k*CKPT_W +: CKPT_W]] <= w_stage[k];
          r_snap_tag[w_slot[k*CKPT_W +: CKPT_W]] <= i_dp_rob_tag[k*TAG_W +: TAG_W];
        end
    end
  end
endmodule

// File: tb/tb_rename_map_ckpt.sv
// tb_rename_map_ckpt: vector table with scoreboarded expectations plus a reset corner sequence
module tb_rename_map_ckpt;
  import rename_map_ckpt_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] i_dp_valid = '0, i_dp_has_dest = '0, i_dp_is_branch = '0;
  logic [9:0] i_dp_dest_idx = '0, i_dp_rs1_idx = '0, i_dp_rs2_idx = '0;
  logic [11:0] i_dp_rob_tag = '0;
  logic [11:0] o_src1_tag, o_src2_tag;
  logic [1:0] o_src1_ready, o_src2_ready;
  logic o_dp_stall;
  logic [0:0] i_cdb_valid = '0;
  logic [5:0] i_cdb_tag = '0, i_retire_tag = '0, i_br_tag = '0;
  logic i_retire_valid = 1'b0, i_br_valid = 1'b0, i_br_mispredict = 1'b0;
  logic [2:0] o_ckpt_free_cnt;
  int n_tests = 0, n_fail = 0;

  rename_map_ckpt dut (
    .clock(clock), .reset(reset), .i_dp_valid(i_dp_valid), .i_dp_has_dest(i_dp_has_dest),
    .i_dp_dest_idx(i_dp_dest_idx), .i_dp_rob_tag(i_dp_rob_tag), .i_dp_is_branch(i_dp_is_branch),
    .i_dp_rs1_idx(i_dp_rs1_idx), .i_dp_rs2_idx(i_dp_rs2_idx), .o_src1_tag(o_src1_tag),
    .o_src2_tag(o_src2_tag), .o_src1_ready(o_src1_ready), .o_src2_ready(o_src2_ready),
    .o_dp_stall(o_dp_stall), .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag),
    .i_retire_valid(i_retire_valid), .i_retire_tag(i_retire_tag), .i_br_valid(i_br_valid),
    .i_br_mispredict(i_br_mispredict), .i_br_tag(i_br_tag), .o_ckpt_free_cnt(o_ckpt_free_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic v, hd;
    logic [4:0] dst;
    logic [5:0] tag;
    logic br;
    logic [4:0] rs1, rs2;
  } way_t;
  typedef struct packed {
    logic [13:0] x0, x1;
    logic st;
    logic [2:0] cnt;
  } exp_t;
  typedef struct packed {
    logic rst;
    way_t w0, w1;
    logic cv;
    logic [5:0] ct;
    logic rv;
    logic [5:0] rt;
    logic bv, bm;
    logic [5:0] bt;
    exp_t e;
  } vec_t;

  vec_t tv[$];
  exp_t sb[$];

  function automatic way_t W(input logic v, hd, input logic [4:0] dst, input logic [5:0] tag,
                             input logic br, input logic [4:0] rs1, rs2);
    return '{v, hd, dst, tag, br, rs1, rs2};
  endfunction
  function automatic way_t L(input logic [4:0] rs1, rs2);
    return '{1'b1, 1'b0, 5'd0, 6'd0, 1'b0, rs1, rs2};
  endfunction
  function automatic logic [13:0] X(input logic [5:0] t1, input logic r1, input logic [5:0] t2, input logic r2);
    return {t1, r1, t2, r2};
  endfunction

  task automatic add(input logic rst, input way_t w0, w1, input logic cv, input logic [5:0] ct,
                     input logic rv, input logic [5:0] rt, input logic bv, bm, input logic [5:0] bt,
                     input logic [13:0] x0, x1, input logic st, input logic [2:0] cnt);
    tv.push_back('{rst, w0, w1, cv, ct, rv, rt, bv, bm, bt, '{x0, x1, st, cnt}});
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst;
    i_dp_valid = {v.w1.v, v.w0.v};
    i_dp_has_dest = {v.w1.hd, v.w0.hd};
    i_dp_is_branch = {v.w1.br, v.w0.br};
    i_dp_dest_idx = {v.w1.dst, v.w0.dst};
    i_dp_rob_tag = {v.w1.tag, v.w0.tag};
    i_dp_rs1_idx = {v.w1.rs1, v.w0.rs1};
    i_dp_rs2_idx = {v.w1.rs2, v.w0.rs2};
    i_cdb_valid = v.cv;
    i_cdb_tag = v.ct;
    i_retire_valid = v.rv;
    i_retire_tag = v.rt;
    i_br_valid = v.bv;
    i_br_mispredict = v.bm;
    i_br_tag = v.bt;
  endtask

  task automatic chk(input string n, input int i, input logic [31:0] got, want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d] got %h want %h", n, i, got, want);
    end
  endtask

  initial begin
    way_t N;
    logic [13:0] Z, R;
    exp_t e;
    N = '0;
    Z = '0;
    R = X(0, 1, 0, 1);
    add(0, N, N, 0,0, 0,0, 0,0,0, Z, Z, 0, 4);
    add(0, W(1,1,5,3,0,0,0), L(5,0), 0,0, 0,0, 0,0,0, R, X(3,0,0,1), 0, 4);
    add(0, L(5,7), N, 1,3, 0,0, 0,0,0, X(3,1,0,1), Z, 0, 4);
    add(0, L(5,0), N, 0,0, 1,3, 0,0,0, X(3,1,0,1), Z, 0, 4);
    add(0, W(1,1,7,4,0,5,7), W(1,1,7,5,0,7,5), 0,0, 0,0, 0,0,0, R, X(4,0,0,1), 0, 4);
    add(0, L(7,7), N, 0,0, 0,0, 0,0,0, X(5,0,5,0), Z, 0, 4);
    add(0, W(1,1,3,10,1,3,0), W(1,0,0,11,1,3,7), 0,0, 0,0, 0,0,0, R, X(10,0,5,0), 0, 4);
    add(0, W(1,0,0,12,1,0,0), W(1,0,0,13,1,0,0), 0,0, 0,0, 0,0,0, R, R, 0, 2);
    add(0, W(1,1,3,14,1,3,0), N, 0,0, 0,0, 0,0,0, X(10,0,0,1), Z, 1, 0);
    add(0, L(3,0), W(1,0,0,15,1,0,0), 0,0, 0,0, 1,0,12, X(10,0,0,1), R, 1, 0);
    add(0, W(1,0,0,15,1,3,0), N, 0,0, 0,0, 0,0,0, X(10,0,0,1), Z, 0, 1);
    add(1, W(1,1,9,20,1,0,0), N, 0,0, 0,0, 0,0,0, Z, Z, 0, 0);
    add(0, L(3,7), L(5,0), 0,0, 0,0, 0,0,0, R, R, 0, 4);
    add(0, W(1,1,3,1,0,0,0), W(1,1,4,2,1,3,0), 0,0, 0,0, 0,0,0, R, X(1,0,0,1), 0, 4);
    add(0, W(1,1,3,6,1,4,3), W(1,1,5,7,0,3,0), 0,0, 0,0, 0,0,0, X(2,0,1,0), X(6,0,0,1), 0, 3);
    add(0, W(1,1,4,8,0,5,0), W(1,1,3,9,1,4,3), 0,0, 0,0, 0,0,0, X(7,0,0,1), X(8,0,6,0), 0, 2);
    add(0, W(1,1,3,12,0,3,5), N, 0,0, 0,0, 1,1,6, X(9,0,7,0), Z, 0, 1);
    add(0, L(3,4), L(5,0), 0,0, 0,0, 0,0,0, X(6,0,2,0), R, 0, 3);
    add(0, W(1,1,3,13,1,3,4), N, 1,2, 1,1, 1,1,2, X(6,0,2,1), Z, 0, 3);
    add(0, L(3,4), N, 0,0, 0,0, 0,0,0, X(0,1,2,1), Z, 0, 4);
    add(0, W(1,0,0,20,1,0,0), W(1,1,6,21,1,0,0), 0,0, 0,0, 0,0,0, R, R, 0, 4);
    add(0, W(1,1,6,22,1,6,0), N, 0,0, 0,0, 0,0,0, X(21,0,0,1), Z, 0, 2);
    add(0, L(6,0), N, 1,21, 0,0, 1,0,22, X(22,0,0,1), Z, 0, 1);
    add(0, L(6,0), N, 0,0, 0,0, 1,1,21, X(22,0,0,1), Z, 0, 2);
    add(0, L(6,0), W(1,0,0,23,1,0,0), 0,0, 0,0, 0,0,0, X(21,1,0,1), R, 0, 3);
    add(0, L(6,0), N, 0,0, 0,0, 1,1,20, X(21,1,0,1), Z, 0, 2);
    add(0, L(6,0), W(1,1,0,30,0,0,0), 0,0, 0,0, 1,0,30, R, R, 0, 4);
    add(0, L(0,6), N, 0,0, 0,0, 0,0,0, R, Z, 0, 4);
    repeat (2) @(posedge clock);
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clock);
      apply(tv[i]);
      sb.push_back(tv[i].e);
      #2;
      e = sb.pop_front();
      chk("src_way0", i, 32'({o_src1_tag[5:0], o_src1_ready[0], o_src2_tag[5:0], o_src2_ready[0]}), 32'(e.x0));
      chk("src_way1", i, 32'({o_src1_tag[11:6], o_src1_ready[1], o_src2_tag[11:6], o_src2_ready[1]}), 32'(e.x1));
      chk("stall", i, 32'(o_dp_stall), 32'(e.st));
      chk("free_cnt", i, 32'(o_ckpt_free_cnt), 32'(e.cnt));
    end
    // two live checkpoints, then reset with a branch still presented
    @(negedge clock);
    apply('{1'b0, W(1,0,0,5,1,0,0), N, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, '0});
    #2 chk("hand_stall", 0, 32'(o_dp_stall), 32'd0);
    chk("hand_cnt", 0, 32'(o_ckpt_free_cnt), 32'd4);
    @(negedge clock);
    #2 chk("hand_cnt", 1, 32'(o_ckpt_free_cnt), 32'd3);
    @(negedge clock);
    reset = 1'b1;
    #2 chk("hand_cnt", 2, 32'(o_ckpt_free_cnt), 32'd2);
    chk("hand_stall", 2, 32'(o_dp_stall), 32'd0);
    @(negedge clock);
    apply('0);
    #2 chk("hand_cnt", 3, 32'(o_ckpt_free_cnt), 32'd4);
    chk("hand_stall", 3, 32'(o_dp_stall), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
